// File: rtl/rail_fault_monitor.sv
// Rail fault monitor: snapshots ADC frames, block-averages each channel and raises
// debounced sticky over/under-voltage flags plus a combined interrupt.
module rail_fault_monitor #(
  parameter int unsigned NUMADCS  = 5,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic [NUMADCS-1:0][7:0] inData,
  input  logic                    data_ready,
  input  logic [NUMADCS-1:0][7:0] ovThresh,
  input  logic [NUMADCS-1:0][7:0] uvThresh,
  input  logic                    fault_clr,
  output logic [NUMADCS-1:0][7:0] avgData,
  output logic                    avg_valid,
  output logic [NUMADCS-1:0]      ovFault,
  output logic [NUMADCS-1:0]      uvFault,
  output logic                    overrun,
  output logic                    fault_irq
);

  localparam int unsigned CH_W  = (NUMADCS > 1) ? $clog2(NUMADCS) : 1;
  localparam int unsigned ACC_W = 8 + AVG_LOG2;
  localparam int unsigned FC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUMADCS - 1);
  localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    accept;
  logic                    scan_en;
  logic                    done_en;
  logic                    drop;
  logic                    last_frame;
  logic [CH_W-1:0]         ch;
  logic [FC_W-1:0]         frame_cnt;
  logic [NUMADCS-1:0][7:0] snap;

  assign last_frame = (frame_cnt == FRAME_LAST);

  // State register
  always_ff @(posedge sclk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (data_ready) state_nxt = S_SCAN;
      S_SCAN:  if (ch == CH_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    accept  = 1'b0;
    scan_en = 1'b0;
    done_en = 1'b0;
    drop    = 1'b0;
    case (state)
      S_IDLE: accept = data_ready;
      S_SCAN: begin
        scan_en = 1'b1;
        drop    = data_ready;
      end
      S_DONE: begin
        done_en = 1'b1;
        drop    = data_ready;
      end
      default: drop = data_ready;
    endcase
  end

  // Snapshot, channel pointer, frame counter and global status
  always_ff @(posedge sclk) begin
    if (rst) begin
      snap      <= '0;
      ch        <= '0;
      frame_cnt <= '0;
      avg_valid <= 1'b0;
      overrun   <= 1'b0;
      fault_irq <= 1'b0;
    end else begin
      if (accept) begin
        snap <= inData;
        ch   <= '0;
      end else if (scan_en && (ch != CH_LAST)) begin
        ch <= ch + CH_W'(1);
      end

      if (done_en) begin
        frame_cnt <= last_frame ? '0 : frame_cnt + FC_W'(1);
      end

      avg_valid <= done_en && last_frame;

      if (drop) begin
        overrun <= 1'b1;
      end else if (fault_clr) begin
        overrun <= 1'b0;
      end

      fault_irq <= (|ovFault) | (|uvFault) | overrun;
    end
  end

  for (genvar i = 0; i < NUMADCS; i++) begin : g_ch
    logic             hit;
    logic             upd;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [7:0]       avg;
    logic [7:0]       avg_q;
    logic [CNT_W-1:0] ov_cnt;
    logic [CNT_W-1:0] uv_cnt;
    logic [CNT_W-1:0] ov_cnt_nxt;
    logic [CNT_W-1:0] uv_cnt_nxt;
    logic             ov_flag;
    logic             uv_flag;

    assign hit = scan_en && (ch == CH_W'(i));
    assign upd = hit && last_frame;
    assign sum = acc + ACC_W'(snap[i]);
    assign avg = 8'(sum >> AVG_LOG2);

    // Consecutive out-of-range counters, saturating at the debounce depth
    always_comb begin
      ov_cnt_nxt = '0;
      uv_cnt_nxt = '0;
      if (avg > ovThresh[i]) begin
        ov_cnt_nxt = (ov_cnt >= DEB_MAX) ? ov_cnt : ov_cnt + CNT_W'(1);
      end
      if (avg < uvThresh[i]) begin
        uv_cnt_nxt = (uv_cnt >= DEB_MAX) ? uv_cnt : uv_cnt + CNT_W'(1);
      end
    end

    always_ff @(posedge sclk) begin
      if (rst) begin
        acc     <= '0;
        avg_q   <= '0;
        ov_cnt  <= '0;
        uv_cnt  <= '0;
        ov_flag <= 1'b0;
        uv_flag <= 1'b0;
      end else begin
        if (hit) begin
          acc <= last_frame ? '0 : sum;
        end

        if (upd) begin
          avg_q  <= avg;
          ov_cnt <= ov_cnt_nxt;
          uv_cnt <= uv_cnt_nxt;
        end else if (fault_clr) begin
          ov_cnt <= '0;
          uv_cnt <= '0;
        end

        // A flag being set outranks a simultaneous clear
        if (upd && (ov_cnt_nxt == DEB_MAX)) begin
          ov_flag <= 1'b1;
        end else if (fault_clr) begin
          ov_flag <= 1'b0;
        end

        if (upd && (uv_cnt_nxt == DEB_MAX)) begin
          uv_flag <= 1'b1;
        end else if (fault_clr) begin
          uv_flag <= 1'b0;
        end
      end
    end

    assign avgData[i] = avg_q;
    assign ovFault[i] = ov_flag;
    assign uvFault[i] = uv_flag;
  end

endmodule

// File: tb/tb_rail_fault_monitor.sv
// Directed bench for rail_fault_monitor: averaging latency, debounce, overrun,
// clear priority and mid-scan reset, all with hand-computed expectations.
module tb_rail_fault_monitor;

  localparam int unsigned NUMADCS  = 5;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned DEBOUNCE = 3;

  logic                    sclk = 1'b0;
  logic                    rst;
  logic [NUMADCS-1:0][7:0] in_data;
  logic                    data_ready;
  logic [NUMADCS-1:0][7:0] ov_thresh;
  logic [NUMADCS-1:0][7:0] uv_thresh;
  logic                    fault_clr;
  logic [NUMADCS-1:0][7:0] avg_data;
  logic                    avg_valid;
  logic [NUMADCS-1:0]      ov_fault;
  logic [NUMADCS-1:0]      uv_fault;
  logic                    overrun;
  logic                    fault_irq;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt;
  int valid_cyc;
  int flag_cyc;
  int irq_cyc;

  rail_fault_monitor #(
    .NUMADCS (NUMADCS),
    .AVG_LOG2(AVG_LOG2),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .inData    (in_data),
    .data_ready(data_ready),
    .ovThresh  (ov_thresh),
    .uvThresh  (uv_thresh),
    .fault_clr (fault_clr),
    .avgData   (avg_data),
    .avg_valid (avg_valid),
    .ovFault   (ov_fault),
    .uvFault   (uv_fault),
    .overrun   (overrun),
    .fault_irq (fault_irq)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One accepted strobe followed by len-1 cycles; optional extra strobe and clear pulse
  task automatic frame(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                       input int len, input int dup_cyc, input int clr_cyc);
    in_data    = '0;
    in_data[0] = c0;
    in_data[1] = c1;
    in_data[2] = c2;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    in_data    = '1;
    valid_cnt  = 0;
    valid_cyc  = 0;
    flag_cyc   = 0;
    irq_cyc    = 0;
    for (int c = 1; c < len; c++) begin
      data_ready = (c == dup_cyc);
      fault_clr  = (c == clr_cyc);
      if (avg_valid) begin
        valid_cnt++;
        if (valid_cyc == 0) valid_cyc = c;
      end
      if ((flag_cyc == 0) && ((|ov_fault) || (|uv_fault) || overrun)) flag_cyc = c;
      if ((irq_cyc == 0) && fault_irq) irq_cyc = c;
      tick();
    end
    data_ready = 1'b0;
    fault_clr  = 1'b0;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    data_ready = 1'b0;
    fault_clr  = 1'b0;
    in_data    = '0;
    ov_thresh  = '1;
    uv_thresh  = '0;
    tick();
    tick();
    check_eq("rst_avg_data", 64'(avg_data), 64'd0);
    check_eq("rst_avg_valid", 64'(avg_valid), 64'd0);
    check_eq("rst_flags", 64'({ov_fault, uv_fault, overrun, fault_irq}), 64'd0);
    rst = 1'b0;
    tick();

    // Averaging and latency
    frame(8'd10, 8'd0, 8'd0, 10, 0, 0);
    check_eq("avg_f1_no_valid", 64'(valid_cnt), 64'd0);
    frame(8'd20, 8'd0, 8'd0, 10, 0, 0);
    frame(8'd30, 8'd0, 8'd0, 10, 0, 0);
    check_eq("avg_f3_no_valid", 64'(valid_cnt), 64'd0);
    frame(8'd40, 8'd0, 8'd0, 10, 0, 0);
    check_eq("avg_valid_cycle", 64'(valid_cyc), 64'd7);
    check_eq("avg_valid_pulses", 64'(valid_cnt), 64'd1);
    check_eq("avg_ch0_25", 64'(avg_data[0]), 64'd25);
    check_eq("avg_ch1_0", 64'(avg_data[1]), 64'd0);
    frame(8'd1, 8'd0, 8'd0, 10, 0, 0);
    frame(8'd1, 8'd0, 8'd0, 10, 0, 0);
    frame(8'd1, 8'd0, 8'd0, 10, 0, 0);
    frame(8'd2, 8'd0, 8'd0, 10, 0, 0);
    check_eq("avg_trunc", 64'(avg_data[0]), 64'd1);

    // Over-voltage: third consecutive over-average sets the flag
    ov_thresh[1] = 8'd200;
    repeat (8) frame(8'd0, 8'd201, 8'd0, 10, 0, 0);
    check_eq("ov_after_2_avgs", 64'(ov_fault), 64'd0);
    check_eq("ov_avg_ch1", 64'(avg_data[1]), 64'd201);
    repeat (3) frame(8'd0, 8'd201, 8'd0, 10, 0, 0);
    frame(8'd0, 8'd201, 8'd0, 10, 0, 0);
    check_eq("ov_flag_cycle", 64'(flag_cyc), 64'd3);
    check_eq("ov_irq_cycle", 64'(irq_cyc), 64'd4);
    check_eq("ov_set", 64'(ov_fault), 64'b00010);
    check_eq("ov_uv_clear", 64'(uv_fault), 64'd0);

    // Clear alone: flags drop next cycle, interrupt one cycle later
    pulse_clr();
    check_eq("clr_ov", 64'(ov_fault), 64'd0);
    check_eq("clr_irq_lag", 64'(fault_irq), 64'd1);
    tick();
    check_eq("clr_irq", 64'(fault_irq), 64'd0);

    // Clear coinciding with the setting average: set wins
    repeat (8) frame(8'd0, 8'd201, 8'd0, 10, 0, 0);
    check_eq("clr_cnt_restart", 64'(ov_fault), 64'd0);
    repeat (3) frame(8'd0, 8'd201, 8'd0, 10, 0, 0);
    frame(8'd0, 8'd201, 8'd0, 10, 0, 2);
    check_eq("clr_set_wins", 64'(ov_fault), 64'b00010);
    pulse_clr();
    tick();

    // At the threshold (not strictly above) never faults
    repeat (12) frame(8'd0, 8'd200, 8'd0, 10, 0, 0);
    check_eq("ov_at_thresh", 64'(ov_fault), 64'd0);
    check_eq("ov_at_thresh_irq", 64'(fault_irq), 64'd0);
    ov_thresh[1] = 8'd255;

    // Under-voltage debounce reset by an in-range average
    uv_thresh[2] = 8'd50;
    repeat (8) frame(8'd0, 8'd0, 8'd40, 10, 0, 0);
    repeat (4) frame(8'd0, 8'd0, 8'd60, 10, 0, 0);
    check_eq("uv_avg_60", 64'(avg_data[2]), 64'd60);
    repeat (8) frame(8'd0, 8'd0, 8'd40, 10, 0, 0);
    check_eq("uv_debounce_reset", 64'(uv_fault), 64'd0);
    repeat (4) frame(8'd0, 8'd0, 8'd40, 10, 0, 0);
    check_eq("uv_set", 64'(uv_fault), 64'b00100);
    pulse_clr();
    uv_thresh[2] = 8'd0;
    tick();
    check_eq("uv_cleared", 64'({ov_fault, uv_fault, overrun, fault_irq}), 64'd0);

    // Minimum spacing of NUMADCS+2 cycles is not an overrun
    repeat (3) frame(8'd8, 8'd0, 8'd0, 7, 0, 0);
    frame(8'd8, 8'd0, 8'd0, 10, 0, 0);
    check_eq("spacing_no_overrun", 64'(overrun), 64'd0);
    check_eq("spacing_valid_cycle", 64'(valid_cyc), 64'd7);
    check_eq("spacing_avg", 64'(avg_data[0]), 64'd8);

    // Overrun: dropped strobe excluded from the block
    frame(8'd12, 8'd0, 8'd0, 10, 3, 0);
    check_eq("ovr_flag_cycle", 64'(flag_cyc), 64'd4);
    check_eq("ovr_irq_cycle", 64'(irq_cyc), 64'd5);
    check_eq("ovr_set", 64'(overrun), 64'd1);
    frame(8'd12, 8'd0, 8'd0, 10, 0, 0);
    frame(8'd12, 8'd0, 8'd0, 10, 0, 0);
    check_eq("ovr_no_early_valid", 64'(valid_cnt), 64'd0);
    frame(8'd12, 8'd0, 8'd0, 10, 0, 0);
    check_eq("ovr_valid_cycle", 64'(valid_cyc), 64'd7);
    check_eq("ovr_avg", 64'(avg_data[0]), 64'd12);

    // Strobe in the DONE cycle is an overrun
    pulse_clr();
    tick();
    frame(8'd20, 8'd0, 8'd0, 10, 6, 0);
    check_eq("ovr_done_cycle", 64'(flag_cyc), 64'd7);
    frame(8'd20, 8'd0, 8'd0, 10, 0, 0);

    // Reset during SCAN discards the partial block
    in_data    = '0;
    in_data[0] = 8'd50;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_avg_data", 64'(avg_data), 64'd0);
    check_eq("midrst_flags", 64'({avg_valid, ov_fault, uv_fault, overrun, fault_irq}), 64'd0);
    rst = 1'b0;
    tick();
    tick();
    repeat (3) frame(8'd100, 8'd0, 8'd0, 10, 0, 0);
    check_eq("midrst_no_early_valid", 64'(valid_cnt), 64'd0);
    frame(8'd100, 8'd0, 8'd0, 10, 0, 0);
    check_eq("midrst_valid_cycle", 64'(valid_cyc), 64'd7);
    check_eq("midrst_avg", 64'(avg_data[0]), 64'd100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
